seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the combinational datapath ALU. Accepts one operation per valid/ready transfer, registers the result with status flags, and holds it until the consumer accepts it. Shifts run either iteratively (one bit per cycle) or single-cycle, selected by parameter. Sits between the decode/operand-fetch stage and writeback in the multi-cycle core.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 2.
- FAST_SHIFT, 0: 0 = iterative shifter, 1 bit/cycle; 1 = single-cycle shift.
- SHW (derived, not overridable): $clog2(WIDTH)+1, shift-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- inp1  in  WIDTH  operand A
- inp2  in  WIDTH  operand B / shift amount
- opc  in  5  opcode
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- zero  out  1  out == 0
- carry  out  1  carry-out (add) / borrow (sub)
- ovf  out  1  signed overflow (add/sub)
- err  out  1  illegal opcode

## Operation
- Opcodes:
  - 0/2/10/11: A+B
  - 1/3: A−B
  - 4/12: A&B
  - 5: A|B
  - 6: A<<B, logical
  - 7: A>>B, logical
  - 8: out=B (jump target pass-through)
  - 9/13: out = (A<B) unsigned, zero-extended
  - 14–31: out=0, err=1
- Shift amount: n = B if B<WIDTH, else n=WIDTH, giving result 0. Upper bits of B beyond SHW are OR-reduced into the clamp.
- carry and ovf are valid only for opcodes 0,1,2,3,10,11; they are 0 for all other opcodes.
  - Sub: carry=1 when A<B unsigned.
  - ovf uses standard two's-complement rules on bit WIDTH−1.
- zero is computed on the final result for every opcode, including illegal opcodes (zero=1).
- States:
  - IDLE: waiting for an operation.
  - SHIFT: iterative shift in progress; holds a working register and a down-counter.
- Transfer occurs on an edge with in_valid && in_ready.
  - Non-shift op, FAST_SHIFT=1, or n=0: result and flags load into the output register; state stays IDLE.
  - Iterative shift with n>0: A loads into the working register, counter=n, go to SHIFT.
- SHIFT: each cycle, shift the working register by 1 and decrement the counter. On the edge where the counter reaches 0, load the output register, set out_valid, and return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and allows back-to-back transfers when the output is consumed in the same cycle.
- out_valid clears on out_ready unless a new result loads on the same edge; the new result wins.
- Output register and flags hold stable while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-SHIFT):
  - state=IDLE; out_valid=0; out, zero, carry, ovf, err=0; working register and counter=0.
  - In-flight operation is discarded.
  - in_ready=1 immediately.

## Timing
- Non-shift op, or any shift with FAST_SHIFT=1: accepted at edge E, out_valid high after E. Latency 1; throughput 1/cycle.
- Iterative shift by n (1..WIDTH): accepted at E, out_valid high after E+n. in_ready=0 for cycles E+1..E+n.
- in_valid is ignored while in_ready=0. The producer holds operands stable until the transfer.
- No combinational path from inp1/inp2/opc to any output. out_ready→in_ready is the only combinational path.

## Test plan
- Reset then add: A=0x7FFFFFFF, B=1, opc=0 → one cycle later out=0x80000000, ovf=1, carry=0, zero=0, err=0.
- Sub borrow: A=3, B=5, opc=1 → out=0xFFFFFFFE, carry=1, ovf=0. Then A=B=9, opc=3 → out=0, zero=1.
- Iterative shift: FAST_SHIFT=0, A=0x1, B=31, opc=6 → in_ready low for 31 cycles, out=0x80000000 after E+31. Then B=40, opc=7 → out=0 after E+32.
- Backpressure: issue 4 ALU ops with out_ready=0 → first result held stable, in_ready=0, and ops 2–4 are not accepted until out_ready=1. Then, with out_ready tied high, results stream one per cycle.
- Illegal/misc opcodes: opc=20 → out=0, err=1, zero=1. opc=9 with A=2, B=0xFFFFFFFF → out=1. opc=8, B=0x40 → out=0x40.
- Reset mid-shift: assert rst_n=0 at cycle 5 of a 20-cycle shift → out_valid=0 and in_ready=1 immediately. The next op completes normally with no stale result.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered ALU stage between operand fetch and writeback.
// One operation is taken per in_valid/in_ready transfer. The result and its status
// flags are registered and held until the consumer takes them with out_ready.
// Shifts run one bit per cycle (FAST_SHIFT=0) or in a single cycle (FAST_SHIFT=1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered          in_ready   operation accepted this cycle
//   inp1       operand A                  inp2       operand B / shift amount
//   opc        5-bit opcode
//   out_valid  result register is full    out_ready  consumer takes the result
//   out        result                     zero       out == 0
//   carry      add carry-out / sub borrow ovf        signed overflow (add/sub)
//   err        illegal opcode
module seq_alu #(
  parameter int WIDTH      = 32,
  parameter int FAST_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [4:0]       opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] WIDTH_W  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   WIDTH_N  = SHW'(WIDTH);
  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;
  logic             is_shift;
  logic             iter_start;
  logic [WIDTH-1:0] work_shifted;
  logic             accept;

  // in_ready is the only combinational output; it depends on out_ready alone.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Shift amount clamp: any B >= WIDTH (upper bits included) becomes WIDTH, result 0.
  assign shamt      = (inp2 >= WIDTH_W) ? WIDTH_N : inp2[SHW-1:0];
  assign is_shift   = (opc == 5'd6) || (opc == 5'd7);
  assign iter_start = is_shift && (FAST_SHIFT == 0) && (shamt != CNT_ZERO);

  assign work_shifted = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};

  // Single-cycle datapath: result and flags for everything loaded straight from IDLE.
  always_comb begin
    sum       = {1'b0, inp1} + {1'b0, inp2};
    // diff[WIDTH] is the borrow, i.e. inp1 < inp2 unsigned.
    diff      = {1'b0, inp1} - {1'b0, inp2};
    alu_res   = {WIDTH{1'b0}};
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (opc)
      5'd0, 5'd2, 5'd10, 5'd11: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (inp1[WIDTH-1] == inp2[WIDTH-1]) && (sum[WIDTH-1] != inp1[WIDTH-1]);
      end
      5'd1, 5'd3: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (inp1[WIDTH-1] != inp2[WIDTH-1]) && (diff[WIDTH-1] != inp1[WIDTH-1]);
      end
      5'd4, 5'd12: alu_res = inp1 & inp2;
      5'd5:        alu_res = inp1 | inp2;
      5'd6:        alu_res = inp1 << shamt;
      5'd7:        alu_res = inp1 >> shamt;
      5'd8:        alu_res = inp2;
      5'd9, 5'd13: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default:     alu_err = 1'b1;
    endcase
  end

  // Next-state: handshake, iterative shifter and output register update.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    // A consumed result drops unless a new one loads on the same edge (set below).
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept && iter_start) begin
          work_d  = inp1;
          cnt_d   = shamt;
          left_d  = (opc == 5'd6);
          state_d = ST_SHIFT;
        end else if (accept) begin
          out_d       = alu_res;
          zero_d      = (alu_res == {WIDTH{1'b0}});
          carry_d     = alu_carry;
          ovf_d       = alu_ovf;
          err_d       = alu_err;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = work_shifted;
        cnt_d  = cnt_q - CNT_ONE;
        // Counter reaching zero on this edge means the shifted value is final.
        if (cnt_q == CNT_ONE) begin
          out_d       = work_shifted;
          zero_d      = (work_shifted == {WIDTH{1'b0}});
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, working and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= {WIDTH{1'b0}};
      cnt_q       <= CNT_ZERO;
      left_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32, iterative shifter).
// Directed cases and randomized operations are compared against a reference
// model that computes results from the opcode rules with 64-bit arithmetic.
module tb_seq_alu;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  inp1;
  logic [W-1:0]  inp2;
  logic [4:0]    opc;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          zero;
  logic          carry;
  logic          ovf;
  logic          err;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W), .FAST_SHIFT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp1      (inp1),
    .inp2      (inp2),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: result, flags and cycles from accept edge to out_valid.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       output logic [31:0] r, output logic c, output logic o,
                       output logic z, output logic e, output int lat);
    longint          sa, sb, ss;
    longint unsigned ua, ub, us;
    int              n;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 0; c = 0; o = 0; e = 0; lat = 0;
    n = (ub >= 64'd32) ? 32 : int'(b);
    case (op)
      5'd0, 5'd2, 5'd10, 5'd11: begin
        us = ua + ub; r = us[31:0]; c = us[32];
        ss = sa + sb; o = (ss > SMAX) || (ss < SMIN);
      end
      5'd1, 5'd3: begin
        r = a - b; c = (ua < ub);
        ss = sa - sb; o = (ss > SMAX) || (ss < SMIN);
      end
      5'd4, 5'd12: r = a & b;
      5'd5:        r = a | b;
      5'd6: begin r = (n >= 32) ? 32'd0 : (a << n); lat = n; end
      5'd7: begin r = (n >= 32) ? 32'd0 : (a >> n); lat = n; end
      5'd8:        r = b;
      5'd9, 5'd13: r = (ua < ub) ? 32'd1 : 32'd0;
      default:     e = 1;
    endcase
    z = (r == 32'd0);
  endtask

  // One complete transfer with out_ready low until the result is checked.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        input string tag);
    logic [31:0] er;
    logic        ec, eo, ez, ee;
    int          lat, k;
    bit          busy_ok;
    model(a, b, op, er, ec, eo, ez, ee, lat);
    k = 0;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    check({tag, " in_ready"}, in_ready, 1);
    inp1 = a; inp2 = b; opc = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands: the DUT must have captured them at the transfer.
    inp1 = $urandom; inp2 = $urandom; opc = 5'($urandom);
    k = 0; busy_ok = 1;
    while (!out_valid && k < 100) begin
      if (in_ready) busy_ok = 0;
      @(posedge clk); #1; k++;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " out"}, out, er);
    check({tag, " flags"}, {zero, carry, ovf, err}, {ez, ec, eo, ee});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drained"}, out_valid, 0);
  endtask

  logic [4:0] ok_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9,
                              5'd10, 5'd11, 5'd12, 5'd13, 5'd20};

  initial begin
    logic [31:0] er, ra, rb;
    logic [4:0]  rop;
    logic        ec, eo, ez, ee;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inp1 = '0; inp2 = '0; opc = '0;
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out", {out, zero, carry, ovf, err}, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(32'h7FFFFFFF, 32'd1, 5'd0, "add_ovf");
    run_op(32'd3, 32'd5, 5'd1, "sub_borrow");
    run_op(32'd9, 32'd9, 5'd3, "sub_zero");
    run_op(32'h1, 32'd31, 5'd6, "shl31");
    run_op(32'hFFFFFFFF, 32'd40, 5'd7, "shr_clamp");
    run_op(32'h1234, 32'h0001_0000, 5'd6, "shl_upper_clamp");
    run_op(32'hA5A5, 32'd0, 5'd7, "shr_zero");
    run_op(32'h1, 32'h2, 5'd20, "illegal");
    run_op(32'd2, 32'hFFFFFFFF, 5'd9, "sltu");
    run_op(32'h0, 32'h40, 5'd8, "pass_b");

    // Backpressure: first result held while later ops wait.
    model(32'd10, 32'd20, 5'd0, er, ec, eo, ez, ee, lat);
    inp1 = 32'd10; inp2 = 32'd20; opc = 5'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp first valid", out_valid, 1);
    inp1 = 32'h80000000; inp2 = 32'h80000000; opc = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp stall ready", in_ready, 0);
      check("bp hold out", {out_valid, out}, {1'b1, er});
    end
    out_ready = 1'b1; #1;
    check("bp ready comb", in_ready, 1);
    ra = inp1; rb = inp2; rop = opc;
    for (int i = 0; i < 10; i++) begin
      model(ra, rb, rop, er, ec, eo, ez, ee, lat);
      inp1 = ra; inp2 = rb; opc = rop;
      @(posedge clk); #1;
      check("stream out", {out_valid, out}, {1'b1, er});
      check("stream flags", {zero, carry, ovf, err}, {ez, ec, eo, ee});
      check("stream ready", in_ready, 1);
      ra = $urandom; rb = $urandom; rop = ok_ops[$urandom_range(0, 12)];
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset in the middle of a 20-cycle shift.
    inp1 = 32'h3; inp2 = 32'd20; opc = 5'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midshift busy", in_ready, 0);
    rst_n = 1'b0; #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst out", out, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (25) begin @(posedge clk); #1; end
    check("post rst no stale", out_valid, 0);
    run_op(32'd5, 32'd6, 5'd10, "post_rst_add");

    // Randomized operations, shifts biased toward in-range amounts.
    for (int i = 0; i < 120; i++) begin
      ra  = $urandom;
      rop = 5'($urandom_range(0, 31));
      rb  = ((rop == 5'd6 || rop == 5'd7) && ($urandom_range(0, 3) != 0))
            ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, rop, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
